// File: rtl/time_entry_pkg.sv
// Shared types and constants for the time_entry keypad front end.
package time_entry_pkg;
    localparam int          BCD_W        = 4;
    localparam logic [3:0]  MAX_SEC_TENS = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic is_digit(input logic [BCD_W-1:0] code);
        return code <= 4'd9;
    endfunction
endpackage

// File: rtl/time_entry_key_edge.sv
// Per-key front end: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce is built only when TIME_ENTRY_DEBOUNCE_EN is defined.
module key_edge #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clrn,
    input  logic key_i,
    output logic rise_o
);
    logic sync1_q, sync2_q, prev_q, lvl;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef TIME_ENTRY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          stable_q;

    // Any low sample restarts the count; the level drops immediately.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (!sync2_q) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            stable_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
    assign lvl = stable_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) prev_q <= 1'b0;
        else       prev_q <= lvl;
    end

    assign rise_o = lvl & ~prev_q;
endmodule

// File: rtl/time_entry.sv
// Keypad time entry: collects M:SS digits, validates, loads and runs a timer chain.
// Optional key debounce via TIME_ENTRY_DEBOUNCE_EN.
module time_entry
    import time_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_code,
    input  logic             key_clear,
    input  logic             key_start,
    input  logic             timer_zero,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             loadn,
    output logic             timer_en,
    output logic             done,
    output logic             err
);
    state_t           state_q, state_d;
    logic [BCD_W-1:0] min_q, tens_q, ones_q, min_d, tens_d, ones_d;
    logic             loadn_q, loadn_d, ten_q, ten_d, done_q, done_d, err_q, err_d;
    logic             armed_q, armed_d;
    logic             valid_rise, start_rise, dig_ok, load_ok;

    key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_valid (
        .clk(clk), .clrn(clrn), .key_i(key_valid), .rise_o(valid_rise));
    key_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .clrn(clrn), .key_i(key_start), .rise_o(start_rise));

    assign dig_ok  = valid_rise & is_digit(key_code);
    assign load_ok = (tens_q <= MAX_SEC_TENS) && ({min_q, tens_q, ones_q} != '0);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        loadn_d = 1'b1;
        ten_d   = ten_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        armed_d = 1'b0;
        if (key_clear) begin
            state_d = ST_IDLE;
            min_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
            ten_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dig_ok) begin
                        min_d   = tens_q;
                        tens_d  = ones_q;
                        ones_d  = key_code;
                        state_d = ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    // Start wins over a digit edge arriving in the same cycle.
                    if (start_rise) begin
                        if (load_ok) begin
                            state_d = ST_LOAD;
                            loadn_d = 1'b0;
                            ten_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (dig_ok) begin
                        min_d  = tens_q;
                        tens_d = ones_q;
                        ones_d = key_code;
                    end
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                    ten_d   = 1'b1;
                end
                ST_RUN: begin
                    // timer_zero is stale on the first RUN cycle, so it is only armed after.
                    armed_d = 1'b1;
                    ten_d   = 1'b1;
                    if (armed_q && timer_zero) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        ten_d   = 1'b0;
                        min_d   = '0;
                        tens_d  = '0;
                        ones_d  = '0;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            min_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            loadn_q <= 1'b1;
            ten_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            loadn_q <= loadn_d;
            ten_q   <= ten_d;
            done_q  <= done_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    assign min_ones = min_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign loadn    = loadn_q;
    assign timer_en = ten_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: directed scenarios then random key operations
// compared against an operation-level model of the keypad timer.
module tb_time_entry;
    localparam int HOLD   = 10;
    localparam int SETTLE = 10;

    logic       clk = 1'b0, clrn = 1'b1;
    logic       key_valid = 1'b0, key_clear = 1'b0, key_start = 1'b0, timer_zero = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] min_ones, sec_tens, sec_ones;
    logic       loadn, timer_en, done, err;

    int n_chk = 0, n_fail = 0;
    int n_load = 0, n_err = 0, n_done = 0;
    logic [11:0] ld_dig = '0;
    logic        ld_ten = 1'b0;

    // Model: three digits and a phase (0 idle, 1 entering, 2 running).
    int mmin = 0, mten = 0, mone = 0, mphase = 0;

    time_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_code(key_code),
        .key_clear(key_clear), .key_start(key_start), .timer_zero(timer_zero),
        .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .loadn(loadn), .timer_en(timer_en), .done(done), .err(err));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clrn) begin
            if (loadn === 1'b0) begin
                n_load <= n_load + 1;
                ld_dig <= {min_ones, sec_tens, sec_ones};
                ld_ten <= timer_en;
            end
            if (err === 1'b1)  n_err  <= n_err + 1;
            if (done === 1'b1) n_done <= n_done + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mdig();
        return 32'(mmin * 256 + mten * 16 + mone);
    endfunction

    task automatic check_op(input string tag, input int l0, input int e0, input int d0,
                            input int el, input int ee, input int ed);
        chk({tag, ".digits"}, {20'd0, min_ones, sec_tens, sec_ones}, mdig());
        chk({tag, ".timer_en"}, 32'(timer_en), 32'(mphase == 2));
        chk({tag, ".loadn"}, 32'(loadn), 32'd1);
        chk({tag, ".loads"}, 32'(n_load - l0), 32'(el));
        chk({tag, ".errs"}, 32'(n_err - e0), 32'(ee));
        chk({tag, ".dones"}, 32'(n_done - d0), 32'(ed));
    endtask

    task automatic op_press(input string tag, input int c);
        int l0, e0, d0;
        l0 = n_load; e0 = n_err; d0 = n_done;
        key_code = 4'(c); key_valid = 1'b1;
        cyc(HOLD);
        key_valid = 1'b0;
        cyc(SETTLE);
        if (mphase < 2 && c <= 9) begin
            mmin = mten; mten = mone; mone = c; mphase = 1;
        end
        check_op(tag, l0, e0, d0, 0, 0, 0);
    endtask

    task automatic op_start(input string tag);
        int l0, e0, d0, el, ee;
        logic [31:0] want;
        l0 = n_load; e0 = n_err; d0 = n_done; el = 0; ee = 0; want = mdig();
        key_start = 1'b1;
        cyc(HOLD);
        key_start = 1'b0;
        cyc(SETTLE);
        if (mphase == 1) begin
            if (mten <= 5 && mdig() != 0) begin el = 1; mphase = 2; end
            else ee = 1;
        end
        check_op(tag, l0, e0, d0, el, ee, 0);
        if (el == 1) begin
            chk({tag, ".load_data"}, {20'd0, ld_dig}, want);
            chk({tag, ".load_ten"}, 32'(ld_ten), 32'd1);
        end
    endtask

    task automatic op_tz(input string tag);
        int l0, e0, d0, ed;
        l0 = n_load; e0 = n_err; d0 = n_done; ed = 0;
        timer_zero = 1'b1;
        cyc(4);
        timer_zero = 1'b0;
        cyc(SETTLE);
        if (mphase == 2) begin
            ed = 1; mmin = 0; mten = 0; mone = 0; mphase = 0;
        end
        check_op(tag, l0, e0, d0, 0, 0, ed);
    endtask

    task automatic op_clear(input string tag, input logic with_start);
        int l0, e0, d0;
        l0 = n_load; e0 = n_err; d0 = n_done;
        key_clear = 1'b1; key_start = with_start;
        cyc(HOLD);
        key_clear = 1'b0; key_start = 1'b0;
        cyc(SETTLE);
        mmin = 0; mten = 0; mone = 0; mphase = 0;
        check_op(tag, l0, e0, d0, 0, 0, 0);
    endtask

    initial begin
        logic seen;
        int   r, c;
        #2 clrn = 1'b0;
        #1;
        chk("reset.digits", {20'd0, min_ones, sec_tens, sec_ones}, 32'd0);
        chk("reset.loadn", 32'(loadn), 32'd1);
        chk("reset.timer_en", 32'(timer_en), 32'd0);
        chk("reset.done_err", {30'd0, done, err}, 32'd0);
        cyc(3);
        clrn = 1'b1;
        cyc(2);

        // 1,3,0 then start, then run to zero
        op_press("p1", 1); op_press("p3", 3); op_press("p0", 0);
        op_start("start130");
        op_press("run_digit", 7);
        op_start("run_start");
        op_tz("tz130");

        // 9,9: seconds tens out of range
        op_press("p9a", 9); op_press("p9b", 9);
        op_start("start099");
        op_press("after_err", 1);
        op_clear("clr1", 1'b0);

        // 1,2,3,4: oldest digit drops out
        op_press("q1", 1); op_press("q2", 2); op_press("q3", 3); op_press("q4", 4);
        op_clear("clr_start", 1'b1);
        op_start("idle_start");
        op_press("code12_idle", 12);
        op_press("q5", 5); op_press("code12_entry", 12);

        // reset asserted while loadn is low
        key_start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (loadn === 1'b0) seen = 1'b1;
        end
        chk("midload.reached", 32'(seen), 32'd1);
        clrn = 1'b0;
        #1;
        chk("midload.loadn", 32'(loadn), 32'd1);
        chk("midload.timer_en", 32'(timer_en), 32'd0);
        chk("midload.digits", {20'd0, min_ones, sec_tens, sec_ones}, 32'd0);
        key_start = 1'b0;
        cyc(3);
        clrn = 1'b1;
        mmin = 0; mten = 0; mone = 0; mphase = 0;
        cyc(SETTLE);
        op_press("post_reset", 4);
        op_start("post_reset_start");
        op_tz("post_reset_tz");

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                c = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                op_press("rnd_press", c);
            end else if (r <= 6) op_start("rnd_start");
            else if (r == 7)     op_clear("rnd_clear", 1'($urandom_range(0, 1)));
            else                 op_tz("rnd_tz");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles a key strobe needs (used only with TIME_ENTRY_DEBOUNCE_EN).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-003 SHALL have port clrn, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port key_valid, input, 1, keypad strobe, level, may be held many cycles.
REQ-005 SHALL have port key_code, input, 4, pressed digit 0-9; codes 10-15 ignored.
REQ-006 SHALL have port key_clear, input, 1, level, clear request.
REQ-007 SHALL have port key_start, input, 1, level, start request; edge-detected.
REQ-008 SHALL have port timer_zero, input, 1, all-zero flag from downstream timer chain.
REQ-009 SHALL have ports min_ones, sec_tens, sec_ones, output, 4 each, BCD load data to timer chain.
REQ-010 SHALL have port loadn, output, 1, active-low one-cycle load strobe to timer chain.
REQ-011 SHALL have port timer_en, output, 1, count enable to timer chain.
REQ-012 SHALL have ports done and err, output, 1 each, single-cycle completion / rejected-start pulses.

Function
REQ-013 SHALL implement FSM IDLE, ENTRY, LOAD, RUN, DONE.
REQ-014 SHALL act on key_valid only at its rising edge, one cycle after the registered edge: digit shifts sec_ones->sec_tens->min_ones, new digit into sec_ones, old min_ones discarded.
REQ-015 SHALL, in IDLE, move to ENTRY on first accepted digit; in ENTRY, remain in ENTRY for further digits.
REQ-016 SHALL, on key_start edge in ENTRY, go to LOAD if sec_tens<=5 and digits not all zero; else pulse err one cycle, stay in ENTRY, digits unchanged.
REQ-017 SHALL, in LOAD, drive loadn=0 for exactly one cycle with data stable, timer_en=1 that cycle, then go to RUN.
REQ-018 SHALL, in RUN, hold timer_en=1, loadn=1, ignore digit and start keys.
REQ-019 SHALL, in RUN, on timer_zero=1 (sampled from the second RUN cycle on), go to DONE; DONE pulses done one cycle, clears timer_en and digits, returns IDLE.
REQ-020 SHALL treat key_clear as highest priority in any state: next cycle digits=0, timer_en=0, loadn=1, state IDLE; start and digit in the same cycle are dropped.
REQ-021 SHALL give key_start priority over a simultaneous digit edge (digit dropped).
REQ-022 SHALL ignore key_start in IDLE (no err).
REQ-023 SHALL keep loadn glitch-free (registered output).

Reset
REQ-024 SHALL, on clrn=0, immediately set state IDLE, digits 0, loadn=1, timer_en=0, done=0, err=0, edge/debounce history cleared, including mid-LOAD or mid-RUN.
REQ-025 SHALL resume normal operation on the first posedge after clrn deasserts.

Configuration
REQ-026 SHALL, with TIME_ENTRY_DEBOUNCE_EN defined, accept key_valid/key_start rises only after DEBOUNCE_CYCLES consecutive stable-high samples (adds DEBOUNCE_CYCLES latency).
REQ-027 SHALL, without TIME_ENTRY_DEBOUNCE_EN, use a 2-flop synchronizer plus edge detect only; 1-cycle latency beyond synchronizer.

Structure
REQ-028 SHALL place FSM state encoding, BCD width (4), MAX_SEC_TENS (5) in shared package time_entry_pkg.
REQ-029 SHALL instantiate one sub-module key_edge (synchronizer, optional debounce, rising-edge pulse), one per key input.

Verification
REQ-030 SHALL cover: keys 1,3,0 then start -> digits 1/3/0, loadn low exactly one cycle, timer_en=1 from load cycle.
REQ-031 SHALL cover: keys 9,9 then start -> sec_tens=9, err pulse, state ENTRY, loadn stays 1.
REQ-032 SHALL cover: keys 1,2,3,4 -> min_ones=2, sec_tens=3, sec_ones=4; key_valid held 10 cycles -> one digit only.
REQ-033 SHALL cover: RUN, timer_zero=1 -> done one cycle, timer_en=0, digits 0, IDLE.
REQ-034 SHALL cover: key_clear with start same cycle in ENTRY -> IDLE, no loadn, no err.
REQ-035 SHALL cover: clrn low during LOAD -> loadn=1 and timer_en=0 asynchronously; key code 12 -> ignored.
